ringbuffer_trig_ctrl: RTL and testbench
=======================================

// Module: ringbuffer_trig_ctrl
// PURPOSE
//  Sequences one ringbuffer (SIZE/WIDTH) per PMT channel: streams ADC samples in while armed.
//  On trigger, captures PRE samples before and POST samples from the trigger address, freezes writes.
//  Then drains the window as a valid/ready stream to the event builder and re-arms after a holdoff.
// PARAMETERS
//  SIZE        8   ringbuffer address width; depth 2**SIZE
//  WIDTH       14  sample width
//  PRE         16  pre-trigger samples; PRE+POST <= 2**SIZE
//  POST        48  samples from trigger address on (>=1)
//  HOLDOFF     4   idle cycles between readout end and re-arm
//  CNTW        8   width of missed-trigger counter
// PORTS
//  clk          in   1      system clock
//  rst          in   1      async, active-high reset
//  enable       in   1      run gate; low in ARM stops writes, ignores trig
//  sample_valid in   1      ADC sample strobe
//  trig         in   1      trigger, level sampled each clk
//  rb_rst       out  1      ringbuffer sync reset
//  rb_wr_en     out  1      ringbuffer write enable
//  rb_aout      in   SIZE   ringbuffer write address
//  rb_rd_en     out  1      ringbuffer read enable (combinational read)
//  rb_ain       out  SIZE   ringbuffer read address
//  rb_dout      in   WIDTH  ringbuffer read data, same cycle as rb_ain
//  out_data     out  WIDTH  stream data, registered
//  out_valid    out  1      stream valid
//  out_ready    in   1      stream ready
//  out_last     out  1      final word of window
//  busy         out  1      high in POST, READ, HOLD
//  missed_cnt   out  CNTW   saturating count of rejected triggers
// BEHAVIOUR
//  Reset: state=ARM; all outputs 0 except rb_rst=1. rb_rst clears on the first clk after rst falls.
//  Reset clears fill_cnt and missed_cnt.
//  Reset mid-readout aborts without completing out_last; partial window is discarded downstream.
//  rb_wr_en = sample_valid & ((ARM & enable) | POST); never asserted in READ/HOLD (buffer frozen).
//  ARM: fill_cnt counts writes, saturates at PRE.
//   trig & enable & fill_cnt==PRE -> T=rb_aout; start=T-PRE mod 2**SIZE; -> POST.
//   trig before fill complete: ignored, missed_cnt++.
//  POST: count writes (incl. the one at T); on POST-th write -> READ, rd_ptr=start, remaining=PRE+POST.
//  READ: when (!out_valid | out_ready) & remaining>0, issue the read.
//   rb_rd_en=1, rb_ain=rd_ptr; out_data<=rb_dout; out_valid<=1.
//   rd_ptr++ (wraps at 2**SIZE); remaining--; out_last<=(remaining==1).
//   out_valid/out_data/out_last hold stable while out_valid & !out_ready.
//   Throughput 1 word/clk with out_ready held high.
//  READ exit: final handshake (out_valid&out_ready&out_last) -> HOLD; out_valid<=0 unless next word.
//  HOLD: HOLDOFF cycles -> ARM, fill_cnt=0 (pre-trigger data must be contiguous).
//  trig high in POST/READ/HOLD, or during ARM prefill: missed_cnt++ per cycle high, saturates at all-ones.
//  trig with sample_valid in same clk: T is the address written that clk.
//  enable low in POST/READ/HOLD: no effect; window completes.
// CONFIGURATION
//  RB_TIMESTAMP_EN defined: free-running WIDTH-bit cycle counter latched at trigger.
//   Emitted as first READ word, before samples; window = PRE+POST+1 words.
//  RB_TIMESTAMP_EN undefined: no counter, window = PRE+POST words, first word is sample at start.
// STRUCTURE
//  mmaps_defs.vh: state encodings (ARM, POST, READ, HOLD), localparam widths shared with event builder.
//  One sub-module: rb_stream_out (output register + valid/ready hold, remaining/last logic).
//  FSM and counters in ringbuffer_trig_ctrl; ringbuffer instantiated beside it at top level.
// TESTING (SIZE=4, PRE=3, POST=5, HOLDOFF=2, samples = incrementing values)
//  Basic: write values 0..9, trig on write of 10.
//   -> out 7,8,...,14; out_last on 14; missed_cnt=0.
//  Wrap: same window placed so start=14.
//   -> rb_ain 14,15,0,..,5, data contiguous in value.
//  Backpressure: out_ready toggles 1010 then low 5 clks.
//   -> no word lost or duplicated; out_data stable while stalled.
//  Early trig: trig after 2 writes since arm -> ignored, missed_cnt=1; later valid trig captured normally.
//  Busy trig: trig pulse during READ -> missed_cnt+1, window unchanged; re-arm after exactly 2 HOLD clks.
//  Reset mid-READ -> out_valid=0 next clk, rb_rst seen for 1 clk, state ARM, fill restarts.
//  With RB_TIMESTAMP_EN: first word = counter value at trig, then 7..14.

Source files
------------

// File: rtl/ringbuffer_trig_ctrl_pkg.sv
// Shared definitions for the per-channel ringbuffer trigger controller.
// State encodings are visible to the event builder through this package.
package ringbuffer_trig_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_POST = 2'd1,
        ST_READ = 2'd2,
        ST_HOLD = 2'd3
    } rb_state_e;

    function automatic logic st_busy(input rb_state_e s);
        return s != ST_ARM;
    endfunction

endpackage

// File: rtl/rb_stream_out.sv
// Readout stage: walks the frozen window, registers each word and holds it
// stable under backpressure; optional leading timestamp word.
module rb_stream_out #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIZE-1:0]  load_ptr,
    input  logic [SIZE+1:0]  load_len,
    input  logic             load_ts,
    input  logic [WIDTH-1:0] ts_value,
    input  logic             active,
    input  logic [WIDTH-1:0] rb_dout,
    input  logic             out_ready,
    output logic             rb_rd_en,
    output logic [SIZE-1:0]  rb_ain,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             done
);

    localparam int RW = SIZE + 2;

    logic [SIZE-1:0] rd_ptr;
    logic [RW-1:0]   remaining;
    logic            ts_pending;
    logic            issue;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        issue    = 1'b0;
        rb_rd_en = 1'b0;
        if (active && (remaining != '0) && (!out_valid || out_ready)) begin
            issue    = 1'b1;
            rb_rd_en = !ts_pending;
        end
    end

    assign rb_ain = rd_ptr;
    assign done   = out_valid && out_ready && out_last;

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from pre-edge values, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            remaining  <= '0;
            ts_pending <= 1'b0;
        end else if (load) begin
            rd_ptr     <= load_ptr;
            remaining  <= load_len;
            ts_pending <= load_ts;
        end else if (issue) begin
            remaining <= remaining - RW'(1);
            if (ts_pending)
                ts_pending <= 1'b0;
            else
                rd_ptr <= rd_ptr + SIZE'(1);
        end
    end

    // A word stays put until accepted; a new one replaces it on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (issue) begin
            out_data  <= ts_pending ? ts_value : rb_dout;
            out_valid <= 1'b1;
            out_last  <= (remaining == RW'(1));
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/ringbuffer_trig_ctrl.sv
// Trigger/readout sequencer for one PMT ringbuffer (ARM, POST, READ, HOLD).
// Define RB_TIMESTAMP_EN to prepend a trigger-time word to every window.
module ringbuffer_trig_ctrl
    import ringbuffer_trig_ctrl_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int WIDTH   = 14,
    parameter int PRE     = 16,
    parameter int POST    = 48,
    parameter int HOLDOFF = 4,
    parameter int CNTW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic             trig,
    output logic             rb_rst,
    output logic             rb_wr_en,
    input  logic [SIZE-1:0]  rb_aout,
    output logic             rb_rd_en,
    output logic [SIZE-1:0]  rb_ain,
    input  logic [WIDTH-1:0] rb_dout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [CNTW-1:0]  missed_cnt
);

    localparam int CW  = SIZE + 1;
    localparam int RW  = SIZE + 2;
    localparam int HCW = $clog2(HOLDOFF + 2);
    localparam logic [CW-1:0]   PRE_C   = CW'(PRE);
    localparam logic [SIZE-1:0] PRE_A   = SIZE'(PRE);
    localparam logic [CW-1:0]   POST_M1 = CW'(POST - 1);
    localparam logic [HCW-1:0]  HOLD_M1 = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
`ifdef RB_TIMESTAMP_EN
    localparam logic TS_EN = 1'b1;
`else
    localparam logic TS_EN = 1'b0;
`endif
    localparam logic [RW-1:0] WIN_LEN = RW'(PRE + POST) + RW'(TS_EN);

    rb_state_e       state, next_state;
    logic [CW-1:0]   fill_cnt;
    logic [CW-1:0]   post_cnt;
    logic [HCW-1:0]  hold_cnt;
    logic [SIZE-1:0] start_ptr;
    logic [SIZE-1:0] load_ptr;
    logic [WIDTH-1:0] ts_value;
    logic            trig_ok;
    logic            trig_rej;
    logic            load;
    logic            rd_done;

    always_comb begin
        trig_ok  = (state == ST_ARM) && trig && enable && (fill_cnt == PRE_C);
        // Disabled ARM ignores trig silently; everywhere else a refused trig is counted.
        trig_rej = trig && !trig_ok && ((state != ST_ARM) || enable);
        load_ptr = (state == ST_ARM) ? rb_aout - PRE_A : start_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ARM;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        rb_wr_en   = 1'b0;
        load       = 1'b0;
        case (state)
            ST_ARM: begin
                rb_wr_en = sample_valid && enable;
                if (trig_ok) begin
                    if (sample_valid && POST == 1) begin
                        next_state = ST_READ;
                        load       = 1'b1;
                    end else begin
                        next_state = ST_POST;
                    end
                end
            end
            ST_POST: begin
                rb_wr_en = sample_valid;
                if (sample_valid && post_cnt == POST_M1) begin
                    next_state = ST_READ;
                    load       = 1'b1;
                end
            end
            ST_READ: begin
                if (rd_done)
                    next_state = (HOLDOFF == 0) ? ST_ARM : ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_M1)
                    next_state = ST_ARM;
            end
            default: next_state = ST_ARM;
        endcase
    end

    assign busy = st_busy(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rb_rst <= 1'b1;
        else     rb_rst <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt   <= '0;
            post_cnt   <= '0;
            hold_cnt   <= '0;
            start_ptr  <= '0;
            missed_cnt <= '0;
        end else begin
            // Leaving ARM discards the fill so pre-trigger data is always contiguous.
            if (state != ST_ARM)
                fill_cnt <= '0;
            else if (rb_wr_en && fill_cnt != PRE_C)
                fill_cnt <= fill_cnt + CW'(1);

            if (trig_ok)
                post_cnt <= sample_valid ? CW'(1) : '0;
            else if (state == ST_POST && rb_wr_en)
                post_cnt <= post_cnt + CW'(1);

            if (state == ST_HOLD)
                hold_cnt <= hold_cnt + HCW'(1);
            else
                hold_cnt <= '0;

            if (trig_ok)
                start_ptr <= rb_aout - PRE_A;

            if (trig_rej && missed_cnt != '1)
                missed_cnt <= missed_cnt + CNTW'(1);
        end
    end

`ifdef RB_TIMESTAMP_EN
    logic [WIDTH-1:0] ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt   <= '0;
            ts_value <= '0;
        end else begin
            ts_cnt <= ts_cnt + WIDTH'(1);
            if (trig_ok)
                ts_value <= ts_cnt;
        end
    end
`else
    assign ts_value = '0;
`endif

    rb_stream_out #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_stream_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_ptr  (load_ptr),
        .load_len  (WIN_LEN),
        .load_ts   (TS_EN),
        .ts_value  (ts_value),
        .active    (state == ST_READ),
        .rb_dout   (rb_dout),
        .out_ready (out_ready),
        .rb_rd_en  (rb_rd_en),
        .rb_ain    (rb_ain),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .done      (rd_done)
    );

endmodule

// File: tb/tb_ringbuffer_trig_ctrl.sv
// Directed bench for ringbuffer_trig_ctrl (SIZE=4, PRE=3, POST=5, HOLDOFF=2)
// with a behavioural 16-deep ringbuffer beside it; samples are incrementing values.
module tb_ringbuffer_trig_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic        trig = 1'b0;
    logic        out_ready = 1'b1;
    logic [13:0] adc = '0;
    logic        rb_rst, rb_wr_en, rb_rd_en, out_valid, out_last, busy;
    logic [3:0]  rb_aout, rb_ain;
    logic [13:0] rb_dout, out_data;
    logic [7:0]  missed_cnt;

    logic [13:0] mem [16];
    logic [3:0]  wp;

    int total = 0;
    int bad   = 0;
    int v     = 0;

    always #5 clk = ~clk;

    ringbuffer_trig_ctrl #(
        .SIZE(4), .WIDTH(14), .PRE(3), .POST(5), .HOLDOFF(2), .CNTW(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .trig         (trig),
        .rb_rst       (rb_rst),
        .rb_wr_en     (rb_wr_en),
        .rb_aout      (rb_aout),
        .rb_rd_en     (rb_rd_en),
        .rb_ain       (rb_ain),
        .rb_dout      (rb_dout),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .missed_cnt   (missed_cnt)
    );

    // Ringbuffer: sync reset of the write pointer, combinational read.
    always @(posedge clk) begin
        if (rb_rst) begin
            wp <= '0;
        end else if (rb_wr_en) begin
            mem[wp] <= adc;
            wp      <= wp + 4'd1;
        end
    end
    assign rb_aout = wp;
    assign rb_dout = mem[rb_ain];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [13:0] d, input logic tg);
        sample_valid = sv;
        adc          = d;
        trig         = tg;
        tick();
        sample_valid = 1'b0;
        trig         = 1'b0;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 14'(v), 1'b0);
            v++;
        end
    endtask

    task automatic trig_write();
        drive(1'b1, 14'(v), 1'b1);
        v++;
    endtask

    function automatic logic ready_pat(input int c);
        if (c < 4) return (c % 2) == 0;
        if (c < 9) return 1'b0;
        return 1'b1;
    endfunction

    // Drains one 8-word window; trig_cyc >= 0 pulses trig on that cycle.
    task automatic run_window(input string name, input int first_val, input bit chk_ain,
                              input int first_ain, input bit bp, input int trig_cyc);
        int got      = 0;
        int rd_cnt   = 0;
        int first_hs = -1;
        int last_hs  = -1;
        logic [13:0] held = '0;
        bit stalled   = 1'b0;
        bit seen_last = 1'b0;
        for (int cyc = 0; cyc < 80 && !seen_last; cyc++) begin
            out_ready = bp ? ready_pat(cyc) : 1'b1;
            trig      = (cyc == trig_cyc);
            #1;
            if (stalled) begin
                check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({name, "_stall_data"}, 32'(out_data), 32'(held));
            end
            if (rb_rd_en && chk_ain) begin
                check({name, "_ain"}, 32'(rb_ain), 32'((first_ain + rd_cnt) % 16));
                rd_cnt++;
            end
            if (out_valid && out_ready) begin
                check({name, "_data"}, 32'(out_data), 32'(first_val + got));
                check({name, "_last"}, 32'(out_last), 32'(got == 7));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                got++;
                if (out_last) seen_last = 1'b1;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            @(posedge clk);
            #1;
        end
        trig      = 1'b0;
        out_ready = 1'b1;
        check({name, "_done"}, 32'(seen_last), 32'd1);
        check({name, "_count"}, 32'(got), 32'd8);
        if (!bp) check({name, "_rate"}, 32'(last_hs - first_hs), 32'd7);
        check({name, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_rb_rst", 32'(rb_rst), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_missed", 32'(missed_cnt), 32'd0);
        check("rst_wr_en", 32'(rb_wr_en), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rb_rst_hold", 32'(rb_rst), 32'd1);
        tick();
        check("rst_rb_rst_clear", 32'(rb_rst), 32'd0);

        // Write gating by enable in ARM
        sample_valid = 1'b1;
        #1;
        check("arm_disabled_wr", 32'(rb_wr_en), 32'd0);
        enable = 1'b1;
        #1;
        check("arm_enabled_wr", 32'(rb_wr_en), 32'd1);
        sample_valid = 1'b0;

        // Basic: 0..9 prefilled, trigger on 10 -> window 7..14
        write_n(10);
        trig_write();
        check("basic_busy_post", 32'(busy), 32'd1);
        write_n(4);
        sample_valid = 1'b1;
        #1;
        check("basic_frozen_wr", 32'(rb_wr_en), 32'd0);
        sample_valid = 1'b0;
        run_window("basic", 7, 1'b0, 0, 1'b0, -1);
        check("basic_missed", 32'(missed_cnt), 32'd0);
        tick(); tick(); tick(); tick();

        // Wrap: trigger at address 1 -> start 14
        write_n(18);
        trig_write();
        write_n(4);
        run_window("wrap", 30, 1'b1, 14, 1'b0, -1);
        tick(); tick(); tick(); tick();

        // Backpressure
        write_n(3);
        trig_write();
        write_n(4);
        run_window("bp", 38, 1'b1, 6, 1'b1, -1);
        tick(); tick(); tick(); tick();

        // Early trigger after two writes is refused, then a real one lands
        write_n(2);
        drive(1'b0, 14'd0, 1'b1);
        check("early_missed", 32'(missed_cnt), 32'd1);
        check("early_not_busy", 32'(busy), 32'd0);
        write_n(1);
        trig_write();
        write_n(4);
        run_window("early", 46, 1'b1, 14, 1'b0, -1);
        tick(); tick(); tick(); tick();

        // Trigger pulse during READ, then exact holdoff
        write_n(3);
        trig_write();
        write_n(4);
        run_window("busytrig", 54, 1'b1, 6, 1'b0, 2);
        check("busytrig_missed", 32'(missed_cnt), 32'd2);
        check("hold1_busy", 32'(busy), 32'd1);
        tick();
        check("hold2_busy", 32'(busy), 32'd1);
        tick();
        check("rearm_busy", 32'(busy), 32'd0);
        tick(); tick();

        // Reset in the middle of READ
        write_n(3);
        trig_write();
        write_n(4);
        tick(); tick(); tick(); tick();
        check("midrd_valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrd_valid", 32'(out_valid), 32'd0);
        check("midrd_last", 32'(out_last), 32'd0);
        check("midrd_busy", 32'(busy), 32'd0);
        check("midrd_rb_rst", 32'(rb_rst), 32'd1);
        check("midrd_missed", 32'(missed_cnt), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrd_rb_rst_hold", 32'(rb_rst), 32'd1);
        tick();
        check("midrd_rb_rst_clear", 32'(rb_rst), 32'd0);
        v = 100;
        write_n(2);
        drive(1'b0, 14'd0, 1'b1);
        check("refill_missed", 32'(missed_cnt), 32'd1);
        write_n(1);
        trig_write();
        write_n(4);
        run_window("refill", 100, 1'b1, 0, 1'b0, -1);
        check("final_missed", 32'(missed_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
